// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX/MEM pipeline stage: control bundle,
// occupancy state encoding and default field widths.
package ex_mem_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_ALUOP_W    = 6;
    localparam int ZERO_REG       = 0;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
    } ctrl_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline register. Build with EX_MEM_SKID_EN to add a
// one-entry skid register and a registered in_ready.
module pipe_skid_buf
    import ex_mem_pkg::*;
#(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data
);

    state_e                 state_q, state_d;
    logic [PAYLOAD_W-1:0]   data_q, data_d;
    logic                   accept, offer;

`ifdef EX_MEM_SKID_EN
    logic [PAYLOAD_W-1:0]   skid_q, skid_d;
    logic                   in_ready_q;

    assign in_ready = in_ready_q;
`else
    // Holds in_ready low until the first clock edge after reset release.
    logic                   live_q;

    assign in_ready = live_q && ((state_q != FULL) || out_ready);
`endif

    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q != EMPTY);
    assign offer     = out_valid && out_ready;
    assign out_data  = data_q;

    // NOTE: every next-state signal gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
`ifdef EX_MEM_SKID_EN
        skid_d  = skid_q;
`endif
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = FULL;
                        data_d  = in_data;
                    end
                end
                FULL: begin
                    if (offer && accept) begin
                        data_d = in_data;
                    end else if (offer) begin
                        state_d = EMPTY;
`ifdef EX_MEM_SKID_EN
                    end else if (accept) begin
                        state_d = SKID;
                        skid_d  = in_data;
`endif
                    end
                end
`ifdef EX_MEM_SKID_EN
                SKID: begin
                    if (offer) begin
                        state_d = FULL;
                        data_d  = skid_q;
                    end
                end
`endif
                default: state_d = EMPTY;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            // NOTE: payload registers are reset too, so outputs read all-zero while reset is held.
            data_q  <= '0;
`ifdef EX_MEM_SKID_EN
            skid_q     <= '0;
            in_ready_q <= 1'b0;
`else
            live_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
`ifdef EX_MEM_SKID_EN
            skid_q     <= skid_d;
            in_ready_q <= (state_d != SKID);
`else
            live_q     <= 1'b1;
`endif
        end
    end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline stage: packs EX results into a valid/ready register, gates
// write controls with valid and exports a forwarding tap. Option: EX_MEM_SKID_EN.
module ex_mem_pipe
    import ex_mem_pkg::*;
#(
    parameter int DATA_W            = DEF_DATA_W,
    parameter int REG_ADDR_W        = DEF_REG_ADDR_W,
    parameter int ALUOP_W           = DEF_ALUOP_W,
    parameter bit ZERO_REG_SUPPRESS = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_store_data,
    input  logic [REG_ADDR_W-1:0] in_dest_reg,
    input  logic [ALUOP_W-1:0]    in_alu_op,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    input  logic                  in_mem_to_reg,
    input  logic                  in_reg_write,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_alu_result,
    output logic [DATA_W-1:0]     out_store_data,
    output logic [REG_ADDR_W-1:0] out_dest_reg,
    output logic [ALUOP_W-1:0]    out_alu_op,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic                  out_mem_to_reg,
    output logic                  out_reg_write,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_reg,
    output logic [DATA_W-1:0]     fwd_data
);

    typedef struct packed {
        logic [ALUOP_W-1:0]    alu_op;
        logic [REG_ADDR_W-1:0] dest_reg;
        logic [DATA_W-1:0]     store_data;
        logic [DATA_W-1:0]     alu_result;
        ctrl_t                 ctrl;
    } payload_t;

    localparam int PAYLOAD_W = $bits(payload_t);

    payload_t in_pl, out_pl;
    logic     dest_is_zero;

    // Writes to the hard-wired zero register are dropped at capture time.
    assign dest_is_zero = (in_dest_reg == REG_ADDR_W'(ZERO_REG));

    always_comb begin
        in_pl                     = '0;
        in_pl.alu_op              = in_alu_op;
        in_pl.dest_reg            = in_dest_reg;
        in_pl.store_data          = in_store_data;
        in_pl.alu_result          = in_alu_result;
        in_pl.ctrl.mem_read       = in_mem_read;
        in_pl.ctrl.mem_write      = in_mem_write;
        in_pl.ctrl.mem_to_reg     = in_mem_to_reg;
        in_pl.ctrl.reg_write      = in_reg_write && !(ZERO_REG_SUPPRESS && dest_is_zero);
    end

    pipe_skid_buf #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pl)
    );

    assign out_alu_result = out_pl.alu_result;
    assign out_store_data = out_pl.store_data;
    assign out_dest_reg   = out_pl.dest_reg;
    assign out_alu_op     = out_pl.alu_op;
    assign out_mem_to_reg = out_pl.ctrl.mem_to_reg;

    // Side-effecting controls read 0 on a bubble, including after a flush.
    assign out_mem_read   = out_valid && out_pl.ctrl.mem_read;
    assign out_mem_write  = out_valid && out_pl.ctrl.mem_write;
    assign out_reg_write  = out_valid && out_pl.ctrl.reg_write;

    assign fwd_valid = out_reg_write;
    assign fwd_reg   = out_pl.dest_reg;
    assign fwd_data  = out_pl.alu_result;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench for ex_mem_pipe; expected stall behaviour follows the
// EX_MEM_SKID_EN setting of the build.
module tb_ex_mem_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_alu_result, in_store_data;
    logic [4:0]  in_dest_reg;
    logic [5:0]  in_alu_op;
    logic        in_mem_read, in_mem_write, in_mem_to_reg, in_reg_write;
    logic        out_valid, out_ready;
    logic [31:0] out_alu_result, out_store_data;
    logic [4:0]  out_dest_reg;
    logic [5:0]  out_alu_op;
    logic        out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write;
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef EX_MEM_SKID_EN
    localparam bit SKID_BUILD = 1'b1;
`else
    localparam bit SKID_BUILD = 1'b0;
`endif

    always #5 clk = ~clk;

    ex_mem_pipe dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_alu_result  (in_alu_result),
        .in_store_data  (in_store_data),
        .in_dest_reg    (in_dest_reg),
        .in_alu_op      (in_alu_op),
        .in_mem_read    (in_mem_read),
        .in_mem_write   (in_mem_write),
        .in_mem_to_reg  (in_mem_to_reg),
        .in_reg_write   (in_reg_write),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_alu_result (out_alu_result),
        .out_store_data (out_store_data),
        .out_dest_reg   (out_dest_reg),
        .out_alu_op     (out_alu_op),
        .out_mem_read   (out_mem_read),
        .out_mem_write  (out_mem_write),
        .out_mem_to_reg (out_mem_to_reg),
        .out_reg_write  (out_reg_write),
        .fwd_valid      (fwd_valid),
        .fwd_reg        (fwd_reg),
        .fwd_data       (fwd_data)
    );

    typedef struct {
        logic        flush, iv, ordy;
        logic [31:0] alu, sd;
        logic [4:0]  dest;
        logic [5:0]  op;
        logic        mr, mw, m2r, rw;
        logic        e_ov, e_ir;
        logic [31:0] e_alu;
        logic [4:0]  e_dest;
        logic        e_mr, e_mw, e_rw, e_fv;
        logic        chk_data;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic iv, input logic [31:0] alu, input logic [4:0] dest,
                         input logic rw, input logic mw);
        in_valid      = iv;
        in_alu_result = alu;
        in_store_data = alu ^ 32'hFFFF_0000;
        in_dest_reg   = dest;
        in_alu_op     = 6'h00;
        in_mem_read   = 1'b0;
        in_mem_write  = mw;
        in_mem_to_reg = 1'b0;
        in_reg_write  = rw;
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 32'hCAFE_F00D, 5'd7, 1'b1, 1'b1);
        in_mem_read = 1'b1;

        // Reset held with live inputs: everything stays zero.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_alu", out_alu_result, 32'd0);
        check("rst_store", out_store_data, 32'd0);
        check("rst_dest", {27'd0, out_dest_reg}, 32'd0);
        check("rst_op", {26'd0, out_alu_op}, 32'd0);
        check("rst_ctrl", {28'd0, out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write}, 32'd0);
        check("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);

        @(negedge clk);
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
        reset = 1'b1;
        #1 check("rel_in_ready_pre_edge", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 check("rel_in_ready_post_edge", {31'd0, in_ready}, 32'd1);

        // Directed table, out_ready held high.
        vecs[0] = '{1'b0,1'b1,1'b1, 32'h10, 32'hAAAA_0001, 5'd8, 6'h01, 1'b0,1'b0,1'b0,1'b1,
                    1'b1,1'b1, 32'h10, 5'd8, 1'b0,1'b0,1'b1,1'b1, 1'b1};
        vecs[1] = '{1'b0,1'b1,1'b1, 32'h20, 32'h2, 5'd0, 6'h02, 1'b0,1'b0,1'b0,1'b1,
                    1'b1,1'b1, 32'h20, 5'd0, 1'b0,1'b0,1'b0,1'b0, 1'b1};
        vecs[2] = '{1'b0,1'b1,1'b1, 32'h30, 32'h1234_5678, 5'd3, 6'h2B, 1'b0,1'b1,1'b0,1'b0,
                    1'b1,1'b1, 32'h30, 5'd3, 1'b0,1'b1,1'b0,1'b0, 1'b1};
        vecs[3] = '{1'b1,1'b1,1'b1, 32'h40, 32'h4, 5'd9, 6'h2B, 1'b0,1'b1,1'b0,1'b1,
                    1'b0,1'b1, 32'h0, 5'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0};
        vecs[4] = '{1'b0,1'b0,1'b1, 32'h0, 32'h0, 5'd0, 6'h00, 1'b0,1'b0,1'b0,1'b0,
                    1'b0,1'b1, 32'h0, 5'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0};
        vecs[5] = '{1'b0,1'b1,1'b1, 32'hDEAD_BEEF, 32'h5, 5'd31, 6'h23, 1'b1,1'b0,1'b1,1'b1,
                    1'b1,1'b1, 32'hDEAD_BEEF, 5'd31, 1'b1,1'b0,1'b1,1'b1, 1'b1};
        vecs[6] = '{1'b0,1'b0,1'b1, 32'h0, 32'h0, 5'd0, 6'h00, 1'b0,1'b0,1'b0,1'b0,
                    1'b0,1'b1, 32'h0, 5'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0};

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            flush         = vecs[i].flush;
            in_valid      = vecs[i].iv;
            out_ready     = vecs[i].ordy;
            in_alu_result = vecs[i].alu;
            in_store_data = vecs[i].sd;
            in_dest_reg   = vecs[i].dest;
            in_alu_op     = vecs[i].op;
            in_mem_read   = vecs[i].mr;
            in_mem_write  = vecs[i].mw;
            in_mem_to_reg = vecs[i].m2r;
            in_reg_write  = vecs[i].rw;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
            check($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_ir});
            check($sformatf("v%0d_mem_read", i), {31'd0, out_mem_read}, {31'd0, vecs[i].e_mr});
            check($sformatf("v%0d_mem_write", i), {31'd0, out_mem_write}, {31'd0, vecs[i].e_mw});
            check($sformatf("v%0d_reg_write", i), {31'd0, out_reg_write}, {31'd0, vecs[i].e_rw});
            check($sformatf("v%0d_fwd_valid", i), {31'd0, fwd_valid}, {31'd0, vecs[i].e_fv});
            if (vecs[i].chk_data) begin
                check($sformatf("v%0d_alu", i), out_alu_result, vecs[i].e_alu);
                check($sformatf("v%0d_dest", i), {27'd0, out_dest_reg}, {27'd0, vecs[i].e_dest});
                check($sformatf("v%0d_store", i), out_store_data, vecs[i].sd);
                check($sformatf("v%0d_op", i), {26'd0, out_alu_op}, {26'd0, vecs[i].op});
                check($sformatf("v%0d_mem_to_reg", i), {31'd0, out_mem_to_reg}, {31'd0, vecs[i].m2r});
                check($sformatf("v%0d_fwd_reg", i), {27'd0, fwd_reg}, {27'd0, vecs[i].e_dest});
                check($sformatf("v%0d_fwd_data", i), fwd_data, vecs[i].e_alu);
            end
        end

        // Stall: entry A held for 3 cycles while producer presents B.
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 32'h100, 5'd4, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("stall_a_valid", {31'd0, out_valid}, 32'd1);
        check("stall_a_in_ready", {31'd0, in_ready}, {31'd0, SKID_BUILD});
        @(negedge clk);
        drive(1'b1, 32'h200, 5'd5, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall%0d_valid", c), {31'd0, out_valid}, 32'd1);
            check($sformatf("stall%0d_alu", c), out_alu_result, 32'h100);
            check($sformatf("stall%0d_dest", c), {27'd0, out_dest_reg}, 32'd4);
            check($sformatf("stall%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_b_valid", {31'd0, out_valid}, 32'd1);
        check("release_b_alu", out_alu_result, 32'h200);
        check("release_b_dest", {27'd0, out_dest_reg}, 32'd5);
        @(negedge clk);
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("release_drained", {31'd0, out_valid}, 32'd0);
        check("release_in_ready", {31'd0, in_ready}, 32'd1);

        // Eight back-to-back entries, no bubbles.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(1'b1, 32'h1000 + 32'(i), 5'(i + 1), 1'b1, 1'b0);
            @(posedge clk);
            #1;
            check($sformatf("stream%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("stream%0d_alu", i), out_alu_result, 32'h1000 + 32'(i));
            check($sformatf("stream%0d_fwd_reg", i), {27'd0, fwd_reg}, 32'(i + 1));
        end
        @(negedge clk);
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 check("stream_end_valid", {31'd0, out_valid}, 32'd0);

        // Reset asserted mid-stall drops the held entry without a clock edge.
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 32'h777, 5'd6, 1'b1, 1'b1);
        @(posedge clk);
        #1 check("mid_rst_pre_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_alu", out_alu_result, 32'd0);
        check("mid_rst_mem_write", {31'd0, out_mem_write}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 check("mid_rst_recover_ready", {31'd0, in_ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
- Parametrised EX/MEM pipeline stage register with a valid/ready handshake, synchronous flush and stall support.
- Sits between the execute stage (ALU) and the memory stage, and carries the ALU result, store data, destination register and MEM/WB control bits.
- Also exports a forwarding tap so the hazard unit can bypass the EX/MEM result back to EX.
- Can optionally be built with a skid buffer, which registers the ready path and breaks the combinational `in_ready` chain.

Parameters:
- DATA_W, 32, width of ALU result and store data
- REG_ADDR_W, 5, width of the destination register index
- ALUOP_W, 6, width of the carried ALU opcode
- ZERO_REG_SUPPRESS, 1, when 1, `reg_write` is forced to 0 for any entry whose `dest_reg` is 0

Ports:
- clk  in  1  stage clock, rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of all held entries (branch/exception)
- in_valid  in  1  EX stage presents an entry
- in_ready  out  1  stage can accept an entry
- in_alu_result  in  DATA_W  ALU result / memory address
- in_store_data  in  DATA_W  rt value for stores
- in_dest_reg  in  REG_ADDR_W  write-back register index
- in_alu_op  in  ALUOP_W  opcode carried for MEM-stage decoding (byte/half access)
- in_mem_read, in_mem_write, in_mem_to_reg, in_reg_write  in  1 each  control bits
- out_valid  out  1  held entry is valid
- out_ready  in  1  MEM stage accepts the entry
- out_alu_result, out_store_data  out  DATA_W  held data
- out_dest_reg  out  REG_ADDR_W
- out_alu_op  out  ALUOP_W
- out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write  out  1 each
- fwd_valid  out  1  equals out_valid AND out_reg_write
- fwd_reg  out  REG_ADDR_W  equals out_dest_reg
- fwd_data  out  DATA_W  equals out_alu_result

Behaviour:
- Reset (reset=0, asynchronous):
  - All held data, opcode and control registers go to 0.
  - out_valid=0. in_ready=1 one cycle after reset deasserts (0 while reset is held).
- Accept: in_valid && in_ready at a rising edge. Offer: out_valid && out_ready.
- Latency: an entry accepted at edge N appears on the out_* ports after edge N, i.e. a one-cycle register.
- Control gating:
  - out_mem_read, out_mem_write and out_reg_write are ANDed with out_valid, so a bubble never writes.
  - When ZERO_REG_SUPPRESS=1, reg_write is also cleared at capture if in_dest_reg==0.
- Data on out_* is stable while out_valid && !out_ready (stall hold).
- Base build (no skid), states EMPTY / FULL:
  - in_ready = !out_valid || out_ready, combinational.
  - EMPTY, accept → FULL.
  - FULL, offer and no accept → EMPTY.
  - FULL, offer and accept → FULL with the new data (back-to-back, full throughput).
  - FULL, stalled → hold.
- Flush:
  - Next state is EMPTY, out_valid=0 and any skid entry is discarded.
  - Takes priority over a simultaneous accept, which is dropped.
  - Data registers need not clear; the gated controls read 0.
- Reset asserted mid-stall drops the held entry immediately.
- in_valid while in_ready=0 has no effect; the producer must hold its data.

Optional Feature:
- Macro: EX_MEM_SKID_EN.
- Defined — adds a one-entry skid register and makes in_ready a registered output. States EMPTY / FULL / SKID:
  - in_ready = (state != SKID).
  - FULL, accept and not offered → SKID; the incoming entry goes to the skid register.
  - SKID, offer → FULL; the skid entry moves to the main register. No accept is possible in SKID.
  - Flush from any state → EMPTY.
  - Throughput stays one entry per cycle when out_ready=1.
- Undefined — base build only; no skid storage is instantiated.

Decomposition:
- Shared package ex_mem_pkg contains:
  - the control bundle struct (mem_read, mem_write, mem_to_reg, reg_write);
  - the state enum (EMPTY, FULL, SKID);
  - the constants ZERO_REG=0 and default widths.
- The natural sub-module is pipe_skid_buf: a generic payload-width valid/ready register with the optional skid. ex_mem_pipe packs its fields into that payload and adds control gating and the forwarding tap.

Test Plan:
- Reset held low with inputs driven → all out_* = 0 and out_valid=0; after release in_ready=1 on the next cycle.
- Accept alu_result=0x0000_0010, dest_reg=8, reg_write=1 with out_ready=1 → one cycle later out_valid=1, fwd_valid=1, fwd_reg=8, fwd_data=0x10.
- Stall: out_ready=0 for 3 cycles with in_valid=1 → out_* holds the first entry.
  - Base build: in_ready=0.
  - Skid build: one extra entry is taken, then in_ready=0, and both entries emerge in order once out_ready=1.
- Flush in the same cycle as an accept of mem_write=1 → out_valid=0 and out_mem_write=0 next cycle, and the flushed entry never appears.
- Accept dest_reg=0 with reg_write=1 and ZERO_REG_SUPPRESS=1 → out_reg_write=0 and fwd_valid=0.
- Stream 8 back-to-back entries with out_ready=1 → 8 consecutive out_valid cycles with data in order and no bubbles.
